branch_resolve_ctrl: RTL and testbench

Sequences branch resolution in EX for the MIPS pipeline. Consumes the branch comparator's actual_takeE. Compares it against the fetch-stage prediction and schedules the PC redirect only after the delay slot has safely reached ID. Buffers BHT training updates in a small FIFO and maintains branch and mispredict statistics counters.

---
 rtl/branch_resolve_ctrl_pkg.sv | 14 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/branch_resolve_ctrl.sv | 140 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared branch-control definitions: FSM state encodings for the EX-stage
// branch resolution sequencer.
package branch_resolve_ctrl_pkg;

  localparam int unsigned BR_STATE_W = 2;

  // Branch resolution FSM states
  localparam logic [BR_STATE_W-1:0] BR_IDLE    = 2'd0;
  localparam logic [BR_STATE_W-1:0] BR_WAIT_DS = 2'd1;
  localparam logic [BR_STATE_W-1:0] BR_REDIR   = 2'd2;

  localparam int unsigned BR_CNT_W = 32;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, first-word fall-through read.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   i_push/i_wdata: write strobe and data (ignored when full)
//   i_pop         : read strobe (ignored when empty)
//   o_rdata       : head entry
//   o_full/o_empty: occupancy flags from the registered count
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rptr];

  // Storage, pointers (wrap naturally at power-of-two depth) and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution sequencer. Compares the branch outcome with the
// fetch prediction, defers the fetch redirect until the delay slot is in ID,
// queues BHT training updates and counts branches / mispredicts.
// Ports:
//   clk, resetn                         : clock, async active-low reset
//   branchE, pred_takeE, actual_takeE   : branch in EX, prediction, outcome
//   pc_branchE, pc_targetE, pc_plus8E   : branch PC, taken target, fall-through
//   stallE, ds_validD, stallF, exc_flush: pipeline status
//   redirect_valid, redirect_pc, flushF : registered fetch redirect
//   stall_reqE                          : EX stall request while update FIFO full
//   upd_valid, upd_pc, upd_taken, upd_ready : BHT update handshake
//   branch_cnt, mispred_cnt             : wrapping statistics
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned UPD_DEPTH = 4,
  parameter int unsigned PC_W      = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                branchE,
  input  logic                pred_takeE,
  input  logic                actual_takeE,
  input  logic [PC_W-1:0]     pc_branchE,
  input  logic [PC_W-1:0]     pc_targetE,
  input  logic [PC_W-1:0]     pc_plus8E,
  input  logic                stallE,
  input  logic                ds_validD,
  input  logic                stallF,
  input  logic                exc_flush,
  output logic                redirect_valid,
  output logic [PC_W-1:0]     redirect_pc,
  output logic                flushF,
  output logic                stall_reqE,
  output logic                upd_valid,
  output logic [PC_W-1:0]     upd_pc,
  output logic                upd_taken,
  input  logic                upd_ready,
  output logic [BR_CNT_W-1:0] branch_cnt,
  output logic [BR_CNT_W-1:0] mispred_cnt
);

  localparam int unsigned UPD_W = PC_W + 1;

  logic [BR_STATE_W-1:0] r_state;
  logic [BR_STATE_W-1:0] w_state_nxt;
  logic                  w_latch;
  logic                  r_redirect_valid;
  logic                  r_flushF;
  logic [PC_W-1:0]       r_redirect_pc;
  logic [BR_CNT_W-1:0]   r_branch_cnt;
  logic [BR_CNT_W-1:0]   r_mispred_cnt;

  logic                  w_resolve;
  logic                  w_mis;
  logic [PC_W-1:0]       w_fix_pc;
  logic                  w_full;
  logic                  w_empty;
  logic [UPD_W-1:0]      w_upd_data;

  assign w_resolve = branchE & ~stallE & ~exc_flush & (r_state == BR_IDLE);
  assign w_mis     = pred_takeE ^ actual_takeE;
  assign w_fix_pc  = actual_takeE ? pc_targetE : pc_plus8E;

  // Next state; exc_flush overrides everything and drops a pending redirect
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    if (exc_flush) begin
      w_state_nxt = BR_IDLE;
    end else begin
      case (r_state)
        BR_IDLE: begin
          if (w_resolve && w_mis) begin
            w_latch     = 1'b1;
            w_state_nxt = ds_validD ? BR_REDIR : BR_WAIT_DS;
          end
        end
        BR_WAIT_DS: if (ds_validD) w_state_nxt = BR_REDIR;
        BR_REDIR:   if (!stallF)   w_state_nxt = BR_IDLE;
        default:    w_state_nxt = BR_IDLE;
      endcase
    end
  end

  // State plus redirect outputs decoded from the next state, so the
  // redirect never has a combinational path from EX inputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= BR_IDLE;
      r_redirect_valid <= 1'b0;
      r_flushF         <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_redirect_valid <= (w_state_nxt == BR_REDIR);
      r_flushF         <= (w_state_nxt == BR_REDIR);
      if (w_latch) r_redirect_pc <= w_fix_pc;
    end
  end

  // Statistics counters, wrapping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_resolve)          r_branch_cnt  <= r_branch_cnt + BR_CNT_W'(1);
      if (w_resolve && w_mis) r_mispred_cnt <= r_mispred_cnt + BR_CNT_W'(1);
    end
  end

  // BHT update queue; full is the pre-pop registered state, so a stalled
  // branch is only released the cycle after a pop frees a slot
  sync_fifo #(
    .WIDTH (UPD_W),
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .i_push  (w_resolve),
    .i_wdata ({pc_branchE, actual_takeE}),
    .i_pop   (upd_ready),
    .o_rdata (w_upd_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign stall_reqE     = branchE & w_full;
  assign upd_valid      = ~w_empty;
  assign upd_pc         = w_empty ? '0 : w_upd_data[UPD_W-1:1];
  assign upd_taken      = ~w_empty & w_upd_data[0];

  assign redirect_valid = r_redirect_valid;
  assign flushF         = r_flushF;
  assign redirect_pc    = r_redirect_pc;
  assign branch_cnt     = r_branch_cnt;
  assign mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with queue-based scoreboard.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        branchE, pred_takeE, actual_takeE;
  logic [31:0] pc_branchE, pc_targetE, pc_plus8E;
  logic        hz_stall;
  logic        stallE;
  logic        ds_validD, stallF, exc_flush;
  logic        redirect_valid, flushF, stall_reqE;
  logic [31:0] redirect_pc;
  logic        upd_valid, upd_taken, upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] branch_cnt, mispred_cnt;

  logic [31:0] exp_redir[$];
  logic [32:0] exp_upd[$];
  int ntot = 0;
  int nerr = 0;

  // hazard unit folds the FIFO stall request into stallE
  assign stallE = hz_stall | stall_reqE;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.UPD_DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .resetn(resetn), .branchE(branchE), .pred_takeE(pred_takeE),
    .actual_takeE(actual_takeE), .pc_branchE(pc_branchE), .pc_targetE(pc_targetE),
    .pc_plus8E(pc_plus8E), .stallE(stallE), .ds_validD(ds_validD), .stallF(stallF),
    .exc_flush(exc_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flushF(flushF), .stall_reqE(stall_reqE), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_ready(upd_ready), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle branch presentation in EX
  task automatic issue(input logic [31:0] pc, input logic pred, input logic act,
                       input logic [31:0] tgt, input logic [31:0] p8, input logic ds,
                       input bit upd_en);
    branchE      = 1'b1;
    pred_takeE   = pred;
    actual_takeE = act;
    pc_branchE   = pc;
    pc_targetE   = tgt;
    pc_plus8E    = p8;
    ds_validD    = ds;
    if (upd_en) exp_upd.push_back({pc, act});
    step();
    branchE = 1'b0;
  endtask

  // Redirect monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (redirect_valid || flushF) chk("flush_eq_valid", 64'(flushF), 64'(redirect_valid));
      if (redirect_valid) begin
        if (exp_redir.size() == 0) begin
          ntot++;
          nerr++;
          $display("FAIL unexpected_redirect: got %0h want none", redirect_pc);
        end else begin
          chk("redirect_pc", 64'(redirect_pc), 64'(exp_redir[0]));
          if (!stallF) void'(exp_redir.pop_front());
        end
      end
    end
  end

  // BHT update monitor
  always @(negedge clk) begin
    if (resetn && upd_valid && upd_ready) begin
      if (exp_upd.size() == 0) begin
        ntot++;
        nerr++;
        $display("FAIL unexpected_update: got %0h want none", {upd_pc, upd_taken});
      end else begin
        chk("upd_entry", 64'({upd_pc, upd_taken}), 64'(exp_upd.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; branchE = 1'b0; pred_takeE = 1'b0; actual_takeE = 1'b0;
    pc_branchE = '0; pc_targetE = '0; pc_plus8E = '0; hz_stall = 1'b0;
    ds_validD = 1'b0; stallF = 1'b0; exc_flush = 1'b0; upd_ready = 1'b1;
    step();
    step();
    // reset state
    chk("rst_redirect_valid", 64'(redirect_valid), 64'h0);
    chk("rst_flushF", 64'(flushF), 64'h0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'h0);
    chk("rst_upd_valid", 64'(upd_valid), 64'h0);
    chk("rst_upd_pc", 64'({upd_pc, upd_taken}), 64'h0);
    chk("rst_branch_cnt", 64'(branch_cnt), 64'h0);
    chk("rst_mispred_cnt", 64'(mispred_cnt), 64'h0);
    branchE = 1'b1;
    #1 chk("rst_stall_req", 64'(stall_reqE), 64'h0);
    branchE = 1'b0;
    resetn = 1'b1;
    step();

    // correct prediction: no redirect, one update
    issue(32'h80000010, 1'b1, 1'b1, 32'h80000100, 32'h80000018, 1'b1, 1'b1);
    chk("t1_redirect", 64'(redirect_valid), 64'h0);
    chk("t1_branch_cnt", 64'(branch_cnt), 64'd1);
    chk("t1_mispred_cnt", 64'(mispred_cnt), 64'd0);
    chk("t1_upd_valid", 64'(upd_valid), 64'h1);
    chk("t1_upd_taken", 64'(upd_taken), 64'h1);
    step();

    // mispredict with delay slot present: redirect next cycle, one cycle long
    exp_redir.push_back(32'hBFC00100);
    issue(32'h80000020, 1'b0, 1'b1, 32'hBFC00100, 32'h80000028, 1'b1, 1'b1);
    chk("t2_redirect_valid", 64'(redirect_valid), 64'h1);
    chk("t2_flushF", 64'(flushF), 64'h1);
    chk("t2_redirect_pc", 64'(redirect_pc), 64'hBFC00100);
    chk("t2_mispred_cnt", 64'(mispred_cnt), 64'd1);
    step();
    chk("t2_single_cycle", 64'(redirect_valid), 64'h0);
    step();

    // delay slot late: no flush while waiting
    exp_redir.push_back(32'h80000028);
    issue(32'h80000020, 1'b1, 1'b0, 32'h80000400, 32'h80000028, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("t3_wait_flushF", 64'(flushF), 64'h0);
      step();
    end
    ds_validD = 1'b1;
    chk("t3_wait_valid", 64'(redirect_valid), 64'h0);
    step();
    chk("t3_redirect_valid", 64'(redirect_valid), 64'h1);
    chk("t3_redirect_pc", 64'(redirect_pc), 64'h80000028);
    step();
    chk("t3_done", 64'(redirect_valid), 64'h0);
    chk("t3_counts", 64'({branch_cnt, mispred_cnt}), {32'd3, 32'd2});

    // fetch stall during REDIR: hold, release after stallF drops
    exp_redir.push_back(32'h80001000);
    stallF = 1'b1;
    issue(32'h80000030, 1'b0, 1'b1, 32'h80001000, 32'h80000038, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_hold_valid", 64'(redirect_valid), 64'h1);
      chk("t4_hold_pc", 64'(redirect_pc), 64'h80001000);
      step();
    end
    stallF = 1'b0;
    chk("t4_last_valid", 64'(redirect_valid), 64'h1);
    step();
    chk("t4_released", 64'(redirect_valid), 64'h0);
    chk("t4_counts", 64'({branch_cnt, mispred_cnt}), {32'd4, 32'd3});

    // FIFO full: fifth branch stalls until one update drains
    upd_ready = 1'b0;
    issue(32'h80000050, 1'b1, 1'b1, 32'h80000500, 32'h80000058, 1'b1, 1'b1);
    issue(32'h80000060, 1'b0, 1'b0, 32'h80000600, 32'h80000068, 1'b1, 1'b1);
    issue(32'h80000070, 1'b1, 1'b1, 32'h80000700, 32'h80000078, 1'b1, 1'b1);
    issue(32'h80000080, 1'b0, 1'b0, 32'h80000800, 32'h80000088, 1'b1, 1'b1);
    branchE = 1'b1; pred_takeE = 1'b1; actual_takeE = 1'b1;
    pc_branchE = 32'h80000090; pc_targetE = 32'h80000900; pc_plus8E = 32'h80000098;
    #1;
    chk("t5_stall_req", 64'(stall_reqE), 64'h1);
    chk("t5_head_pc", 64'(upd_pc), 64'h80000050);
    step();
    chk("t5_stall_held", 64'(stall_reqE), 64'h1);
    chk("t5_no_push_cnt", 64'(branch_cnt), 64'd8);
    upd_ready = 1'b1;
    chk("t5_stall_prepop", 64'(stall_reqE), 64'h1);
    step();
    upd_ready = 1'b0;
    chk("t5_stall_clear", 64'(stall_reqE), 64'h0);
    chk("t5_cnt_before", 64'(branch_cnt), 64'd8);
    exp_upd.push_back({32'h80000090, 1'b1});
    step();
    branchE = 1'b0;
    chk("t5_cnt_after", 64'(branch_cnt), 64'd9);
    upd_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t5_drained", 64'(upd_valid), 64'h0);

    // exc_flush in WAIT_DS beats a same-cycle delay-slot arrival
    issue(32'h800000A0, 1'b1, 1'b0, 32'h800000B0, 32'h80002000, 1'b0, 1'b1);
    chk("t6_wait", 64'(redirect_valid), 64'h0);
    chk("t6_counts", 64'({branch_cnt, mispred_cnt}), {32'd10, 32'd4});
    exc_flush = 1'b1;
    ds_validD = 1'b1;
    step();
    exc_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_redirect", 64'(redirect_valid), 64'h0);
      step();
    end
    chk("t6_counts_kept", 64'({branch_cnt, mispred_cnt}), {32'd10, 32'd4});

    // asynchronous reset in the middle of a redirect
    issue(32'h800000C0, 1'b0, 1'b1, 32'h80003000, 32'h800000C8, 1'b1, 1'b0);
    chk("t7_redir_up", 64'(redirect_valid), 64'h1);
    chk("t7_redir_pc", 64'(redirect_pc), 64'h80003000);
    #1 resetn = 1'b0;
    #1;
    chk("t7_rst_valid", 64'(redirect_valid), 64'h0);
    chk("t7_rst_flushF", 64'(flushF), 64'h0);
    chk("t7_rst_cnt", 64'(branch_cnt), 64'h0);
    chk("t7_rst_upd", 64'(upd_valid), 64'h0);
    step();
    resetn = 1'b1;
    step();
    step();

    chk("redir_queue_empty", 64'(exp_redir.size()), 64'h0);
    chk("upd_queue_empty", 64'(exp_upd.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", ntot, nerr);
    $finish;
  end

endmodule
